hv_binarize_packer: RTL and testbench

- Consumes the stream of signed per-dimension sums produced by the HD encoder's adder tree.
- Quantizes each sum to one hypervector bit.
- Packs the bits LSB-first into WORD_WIDTH-bit words and sends them to the hypervector memory/similarity stage over a valid/ready interface.
- Tracks the dimension index and marks the final word of every NUM_DIMS-bit hypervector.

---
 rtl/hd_pkg.sv | 16 +
 rtl/hv_out_slot.sv | 61 ++++++
 rtl/hv_binarize_packer.sv | 122 ++++++++++++
 tb/tb_hv_binarize_packer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_pkg.sv
// rtl/hd_pkg.sv - shared HD encoder widths, defaults and typedefs
//
// Shared by the adder tree, the binarize/packer and the similarity stage.
//   DIM_WIDTH_DEF  : width of a signed per-dimension sum
//   WORD_WIDTH_DEF : packed hypervector word width
//   NUM_DIMS_DEF   : dimensions per hypervector (multiple of WORD_WIDTH_DEF)
package hd_pkg;

    localparam int DIM_WIDTH_DEF  = 16;
    localparam int WORD_WIDTH_DEF = 32;
    localparam int NUM_DIMS_DEF   = 1024;

    typedef logic signed [DIM_WIDTH_DEF-1:0] dim_sum_t;
    typedef logic        [WORD_WIDTH_DEF-1:0] hv_word_t;

endpackage

// File: rtl/hv_out_slot.sv
// rtl/hv_out_slot.sv - one-entry output register for packed hypervector words
//
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   load_i           : capture load_word_i/load_last_i this cycle
//   load_word_i      : completed word to capture
//   load_last_i      : completed word holds the final dimension
//   out_ready_i      : downstream accepts the held word
//   out_word_o       : held word
//   out_valid_o      : held word is valid
//   out_last_o       : held word is the last of its hypervector
module hv_out_slot #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [WORD_WIDTH-1:0] load_word_i,
    input  logic                  load_last_i,
    input  logic                  out_ready_i,
    output logic [WORD_WIDTH-1:0] out_word_o,
    output logic                  out_valid_o,
    output logic                  out_last_o
);

    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;

    // A load always wins: when it coincides with a drain the new word
    // replaces the old one and valid stays high.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load_i) begin
            word_d  = load_word_i;
            last_d  = load_last_i;
            valid_d = 1'b1;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_word_o  = word_q;
    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/hv_binarize_packer.sv
// rtl/hv_binarize_packer.sv - quantize dimension sums to bits and pack into words
//
// Optional feature macro: HVB_THRESH_EN (adds the threshold port; otherwise
// the quantizer is the sign bit, i.e. threshold fixed at 0).
//
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   clear        : synchronous abort of the hypervector being packed
//   in_data      : signed dimension sum
//   in_valid     : in_data valid
//   in_ready     : block accepts in_data this cycle
//   threshold    : signed quantization threshold (HVB_THRESH_EN only)
//   out_word     : packed bits, first dimension in bit 0
//   out_valid    : out_word valid
//   out_ready    : downstream accepts out_word
//   out_last     : out_word holds dimension NUM_DIMS-1
module hv_binarize_packer
    import hd_pkg::*;
#(
    parameter int DIM_WIDTH  = DIM_WIDTH_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int NUM_DIMS   = NUM_DIMS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DIM_WIDTH-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
`ifdef HVB_THRESH_EN
    input  logic [DIM_WIDTH-1:0]  threshold,
`endif
    output logic [WORD_WIDTH-1:0] out_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int BW = $clog2(WORD_WIDTH);
    localparam int DW = $clog2(NUM_DIMS);
    localparam logic [BW-1:0] BIT_MAX = BW'(WORD_WIDTH - 1);
    localparam logic [DW-1:0] DIM_MAX = DW'(NUM_DIMS - 1);

    logic [WORD_WIDTH-1:0] acc_q, acc_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]         dim_cnt_q, dim_cnt_d;

    logic                  q_bit;
    logic                  bit_last;
    logic                  dim_last;
    logic                  accept;
    logic                  load;
    logic [WORD_WIDTH-1:0] acc_ins;

`ifdef HVB_THRESH_EN
    assign q_bit = ($signed(in_data) >= $signed(threshold));
`else
    // x >= 0 for a signed value is simply a clear sign bit.
    assign q_bit = ~in_data[DIM_WIDTH-1];
`endif

    assign bit_last = (bit_cnt_q == BIT_MAX);
    assign dim_last = (dim_cnt_q == DIM_MAX);

    // Only the completing bit needs a free output slot; earlier bits of the
    // next word keep filling the accumulator while the output is stalled.
    assign in_ready = !clear && (!bit_last || !out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign load     = accept && bit_last;

    always_comb begin
        acc_ins            = acc_q;
        acc_ins[bit_cnt_q] = q_bit;
    end

    always_comb begin
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        dim_cnt_d = dim_cnt_q;
        if (clear) begin
            acc_d     = '0;
            bit_cnt_d = '0;
            dim_cnt_d = '0;
        end else if (accept) begin
            if (bit_last) begin
                acc_d     = '0;
                bit_cnt_d = '0;
            end else begin
                acc_d     = acc_ins;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
            dim_cnt_d = dim_last ? '0 : dim_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            bit_cnt_q <= '0;
            dim_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            dim_cnt_q <= dim_cnt_d;
        end
    end

    hv_out_slot #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_out_slot (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .load_word_i (acc_ins),
        .load_last_i (dim_last),
        .out_ready_i (out_ready),
        .out_word_o  (out_word),
        .out_valid_o (out_valid),
        .out_last_o  (out_last)
    );

endmodule

// File: tb/tb_hv_binarize_packer.sv
// tb/tb_hv_binarize_packer.sv - self-checking bench for hv_binarize_packer
module tb_hv_binarize_packer;

    localparam int DWD = 16;
    localparam int WW  = 8;
    localparam int ND  = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           clear = 1'b0;
    logic [DWD-1:0] in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DWD-1:0] threshold = '0;
    logic [WW-1:0]  out_word;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           out_last;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [WW-1:0] w;
        logic          l;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int            m_bits = 0;
    int            m_dim  = 0;
    logic [WW-1:0] m_acc  = '0;

    always #5 clk = ~clk;

    hv_binarize_packer #(
        .DIM_WIDTH  (DWD),
        .WORD_WIDTH (WW),
        .NUM_DIMS   (ND)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef HVB_THRESH_EN
        .threshold (threshold),
`endif
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    // Output scoreboard: every handshaken word must match the oldest expectation.
    always @(negedge clk) begin
        #2;
        if (reset && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected: got word=%h last=%b, required none", out_word, out_last);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_word !== mon_e.w || out_last !== mon_e.l) begin
                    bad++;
                    $display("FAIL out_word: got word=%h last=%b, required word=%h last=%b",
                             out_word, out_last, mon_e.w, mon_e.l);
                end
            end
        end
    end

    task automatic model_reset();
        m_bits = 0;
        m_dim  = 0;
        m_acc  = '0;
    endtask

    task automatic model_accept(input logic [DWD-1:0] d);
        logic b;
`ifdef HVB_THRESH_EN
        b = ($signed(d) >= $signed(threshold));
`else
        b = ($signed(d) >= 0);
`endif
        m_acc[m_bits] = b;
        if (m_bits == WW - 1) begin
            exp_q.push_back('{w: m_acc, l: (m_dim == ND - 1)});
            m_acc  = '0;
            m_bits = 0;
        end else begin
            m_bits++;
        end
        m_dim = (m_dim == ND - 1) ? 0 : m_dim + 1;
    endtask

    // Present one sum and wait (bounded) until it is accepted.
    task automatic send(input logic [DWD-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
        end else begin
            model_accept(d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain_check(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        total++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d out_valid=%b, required 0 and 0", name, exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_word !== '0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b word=%h last=%b, required 0 00 0", out_valid, out_word, out_last);
        end
        reset = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_stream();
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send((i % 2 == 0) ? 16'sd5 : -16'sd3);
            if (i == 7 || i == 15) begin
                total++;
                if (out_valid !== 1'b1 || out_word !== 8'h55 || out_last !== (i == 15)) begin
                    bad++;
                    $display("FAIL stream_word%0d: valid=%b word=%h last=%b, required 1 55 %b",
                             i / 8, out_valid, out_word, out_last, (i == 15));
                end
            end
        end
        drain_check("stream");
    endtask

    task automatic test_extremes();
        logic [DWD-1:0] vals [4];
        vals[0] = 16'h0000;
        vals[1] = 16'hFFFF;
        vals[2] = 16'h7FFF;
        vals[3] = 16'h8000;
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(vals[i % 4]);
        total++;
        if (out_valid !== 1'b1 || out_word !== 8'h55 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL extremes_word: valid=%b word=%h last=%b, required 1 55 0", out_valid, out_word, out_last);
        end
        drain_check("extremes");
    endtask

    task automatic test_backpressure();
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'sd1);
        for (int i = 0; i < 7; i++) send((i % 2 == 0) ? 16'sd5 : -16'sd3);
        @(negedge clk);
        in_data  = -16'sd3;
        in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 8'hFF) begin
            bad++;
            $display("FAIL bp_stall: in_ready=%b valid=%b word=%h, required 0 1 ff", in_ready, out_valid, out_word);
        end
        @(negedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0 || out_word !== 8'hFF || out_last !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold: in_ready=%b word=%h last=%b, required 0 ff 0", in_ready, out_word, out_last);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b, required 1", in_ready);
        end else begin
            model_accept(in_data);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_word !== 8'h55 || out_last !== 1'b1) begin
            bad++;
            $display("FAIL bp_replace: valid=%b word=%h last=%b, required 1 55 1", out_valid, out_word, out_last);
        end
        drain_check("bp");
    endtask

    task automatic test_clear();
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(-16'sd1);
        @(negedge clk);
        clear    = 1'b1;
        in_data  = 16'sd1;
        in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL clear_blocks: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_no_word: out_valid=%b, required 0", out_valid);
        end
        for (int i = 0; i < 8; i++) send(16'sd1);
        total++;
        if (out_valid !== 1'b1 || out_word !== 8'hFF || out_last !== 1'b0) begin
            bad++;
            $display("FAIL clear_restart: valid=%b word=%h last=%b, required 1 ff 0", out_valid, out_word, out_last);
        end
        drain_check("clear");
    endtask

    task automatic test_reset_mid();
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'sd7);
        for (int i = 0; i < 3; i++) send(16'sd7);
        #2;
        reset = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || out_word !== '0) begin
            bad++;
            $display("FAIL reset_mid_async: valid=%b word=%h, required 0 00", out_valid, out_word);
        end
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send((i < 4) ? 16'sd2 : -16'sd2);
        total++;
        if (out_valid !== 1'b1 || out_word !== 8'h0F || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_restart: valid=%b word=%h last=%b, required 1 0f 0", out_valid, out_word, out_last);
        end
        drain_check("reset_mid");
    endtask

`ifdef HVB_THRESH_EN
    task automatic test_threshold();
        logic [DWD-1:0] vals [4];
        vals[0] = 16'd100;
        vals[1] = 16'd99;
        vals[2] = 16'd200;
        vals[3] = 16'hFF38;
        reset_dut();
        threshold = 16'd100;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(vals[i % 4]);
        total++;
        if (out_valid !== 1'b1 || out_word !== 8'h55) begin
            bad++;
            $display("FAIL thresh_word: valid=%b word=%h, required 1 55", out_valid, out_word);
        end
        drain_check("thresh");
        threshold = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_extremes();
        test_backpressure();
        test_clear();
        test_reset_mid();
`ifdef HVB_THRESH_EN
        test_threshold();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
